// File: rtl/sha256_digest_reader_pkg.sv
// Shared definitions for the SHA-256 digest read-out path.
//   DIGEST_W / WORD_W : digest and hash-word widths
//   H0_INIT..H7_INIT  : SHA-256 initial hash values (used by the hash-state registers)
//   state_t           : read-out FSM encoding (ST_IDLE, ST_STREAM)
//   last_beat()       : index of the final beat for a given beat width
package sha256_digest_reader_pkg;

    localparam int DIGEST_W = 256;
    localparam int WORD_W   = 32;

    localparam logic [WORD_W-1:0] H0_INIT = 32'h6a09e667;
    localparam logic [WORD_W-1:0] H1_INIT = 32'hbb67ae85;
    localparam logic [WORD_W-1:0] H2_INIT = 32'h3c6ef372;
    localparam logic [WORD_W-1:0] H3_INIT = 32'ha54ff53a;
    localparam logic [WORD_W-1:0] H4_INIT = 32'h510e527f;
    localparam logic [WORD_W-1:0] H5_INIT = 32'h9b05688c;
    localparam logic [WORD_W-1:0] H6_INIT = 32'h1f83d9ab;
    localparam logic [WORD_W-1:0] H7_INIT = 32'h5be0cd19;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    // Beat counter is 5 bits: enough for 32 byte-wide beats.
    function automatic logic [4:0] last_beat(input int out_w);
        return 5'(DIGEST_W / out_w - 1);
    endfunction

endpackage

// File: rtl/sha256_digest_reader.sv
// Read-out end of the SHA-256 hash-state registers.
// Captures the 256-bit digest {H0..H7} in one cycle and streams it out
// big-endian (H0 MSB first) as OUT_W-bit beats over valid/ready.
// Ports:
//   clk, reset     : clock (rising edge), asynchronous active-high reset
//   digest         : {H0,...,H7}, H0 in [255:224]
//   digest_valid   : digest offered; taken when digest_valid && digest_ready
//   digest_ready   : high while idle
//   out_data       : current beat
//   out_valid      : beat available
//   out_ready      : sink accepts the beat
//   out_last       : final beat of the digest
//   overrun        : sticky, a digest was offered while busy
//   clear_overrun  : synchronous clear of overrun (a new overrun wins)
module sha256_digest_reader
    import sha256_digest_reader_pkg::*;
#(
    parameter int OUT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DIGEST_W-1:0] digest,
    input  logic                digest_valid,
    output logic                digest_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_last,
    output logic                overrun,
    input  logic                clear_overrun
);

    localparam logic [4:0] LAST_BEAT = last_beat(OUT_W);

    generate
        if (OUT_W != 8 && OUT_W != 32) begin : g_bad_out_w
            $error("sha256_digest_reader: OUT_W must be 8 or 32");
        end
    endgenerate

    state_t              state;
    logic [DIGEST_W-1:0] shift_q;
    logic [4:0]          count_q;
    logic                overrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            count_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (digest_valid) begin
                        shift_q <= digest;
                        count_q <= '0;
                        state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (out_ready) begin
                        // Zero fill leaves the register clear once the digest is drained.
                        shift_q <= {shift_q[DIGEST_W-OUT_W-1:0], {OUT_W{1'b0}}};
                        if (count_q == LAST_BEAT) begin
                            count_q <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            count_q <= count_q + 5'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Any offer outside IDLE is an overrun, including the final-beat cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (digest_valid && state != ST_IDLE) begin
            overrun_q <= 1'b1;
        end else if (clear_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    // Outputs decode registered state only; out_ready never reaches digest_ready.
    assign digest_ready = (state == ST_IDLE);
    assign out_valid    = (state == ST_STREAM);
    assign out_last     = (state == ST_STREAM) && (count_q == LAST_BEAT);
    assign out_data     = shift_q[DIGEST_W-1 -: OUT_W];
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_sha256_digest_reader.sv
module tb_sha256_digest_reader;

    logic         clk = 1'b0;
    logic         reset;
    logic [255:0] dg   [2];
    logic         dv   [2];
    logic         ordy [2];
    logic         clr  [2];
    logic         drdy [2];
    logic         ovld [2];
    logic         olast[2];
    logic         ovr  [2];
    logic [31:0]  odata32;
    logic [7:0]   odata8;

    int total = 0;
    int bad   = 0;
    int wid[2] = '{32, 8};
    logic [31:0] exp_q[$];
    logic exp_ov[2];

    localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    always #5 clk = ~clk;

    sha256_digest_reader #(.OUT_W(32)) dut32 (
        .clk(clk), .reset(reset), .digest(dg[0]), .digest_valid(dv[0]),
        .digest_ready(drdy[0]), .out_data(odata32), .out_valid(ovld[0]),
        .out_ready(ordy[0]), .out_last(olast[0]), .overrun(ovr[0]),
        .clear_overrun(clr[0])
    );

    sha256_digest_reader #(.OUT_W(8)) dut8 (
        .clk(clk), .reset(reset), .digest(dg[1]), .digest_valid(dv[1]),
        .digest_ready(drdy[1]), .out_data(odata8), .out_valid(ovld[1]),
        .out_ready(ordy[1]), .out_last(olast[1]), .overrun(ovr[1]),
        .clear_overrun(clr[1])
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int k, output logic v, output logic [31:0] d,
                      output logic l, output logic r, output logic o);
        v = ovld[k];
        d = (k == 0) ? odata32 : {24'b0, odata8};
        l = olast[k];
        r = drdy[k];
        o = ovr[k];
    endtask

    task automatic check_idle_reset(input int k, input string tag);
        logic v, l, r, o;
        logic [31:0] d;
        rd(k, v, d, l, r, o);
        chk({tag, "_valid"}, v, 1'b0);
        chk({tag, "_last"},  l, 1'b0);
        chk({tag, "_data"},  d, 32'h0);
        chk({tag, "_ovr"},   o, 1'b0);
        chk({tag, "_ready"}, r, 1'b1);
    endtask

    function automatic logic [255:0] rnd_digest();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom();
        return t;
    endfunction

    // Offer a digest while idle; the model lists the beats MSB first.
    task automatic capture(input int k, input logic [255:0] d);
        logic v, l, r, o;
        logic [31:0] dd;
        logic [255:0] t;
        int w;
        w = wid[k];
        rd(k, v, dd, l, r, o);
        chk($sformatf("w%0d_cap_ready", w), r, 1'b1);
        dg[k] = d;
        dv[k] = 1'b1;
        tick();
        dv[k] = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 256 / w; i++) begin
            t = d >> (256 - (i + 1) * w);
            exp_q.push_back((w == 32) ? t[31:0] : {24'b0, t[7:0]});
        end
    endtask

    // mode 0: ready always 1, 1: ready 1,0,1,0..., 2: random ready
    task automatic drain(input int k, input int mode, input int nbeats,
                         input int poke1, input int poke2, input int clrc,
                         output int cycles);
        int acc, cyc, want, w;
        logic v, l, r, o, rdyv, pk, cl;
        logic [31:0] d;
        acc = 0;
        cyc = 0;
        w = wid[k];
        want = (nbeats < exp_q.size()) ? nbeats : exp_q.size();
        while (exp_q.size() > 0 && acc < nbeats && cyc < 300) begin
            rd(k, v, d, l, r, o);
            chk($sformatf("w%0d_valid", w), v, 1'b1);
            chk($sformatf("w%0d_data_beat%0d", w, acc), d, exp_q[0]);
            chk($sformatf("w%0d_last_beat%0d", w, acc), l, exp_q.size() == 1);
            chk($sformatf("w%0d_dready_busy", w), r, 1'b0);
            rdyv = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            pk = (cyc == poke1) || (cyc == poke2);
            cl = (cyc == clrc);
            ordy[k] = rdyv;
            dv[k] = pk;
            clr[k] = cl;
            if (pk) dg[k] = rnd_digest();
            if (pk) exp_ov[k] = 1'b1;
            else if (cl) exp_ov[k] = 1'b0;
            tick();
            if (rdyv) begin
                void'(exp_q.pop_front());
                acc++;
            end
            cyc++;
            dv[k] = 1'b0;
            clr[k] = 1'b0;
            rd(k, v, d, l, r, o);
            chk($sformatf("w%0d_overrun", w), o, exp_ov[k]);
        end
        chk($sformatf("w%0d_beats_accepted", w), acc, want);
        if (exp_q.size() == 0) begin
            rd(k, v, d, l, r, o);
            chk($sformatf("w%0d_bubble_ready", w), r, 1'b1);
            chk($sformatf("w%0d_bubble_valid", w), v, 1'b0);
            chk($sformatf("w%0d_bubble_last", w), l, 1'b0);
        end
        cycles = cyc;
    endtask

    initial begin
        int c, c1, c2;
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            dg[k] = '0; dv[k] = 1'b0; ordy[k] = 1'b0; clr[k] = 1'b0; exp_ov[k] = 1'b0;
        end
        #3;
        check_idle_reset(0, "rst32");
        check_idle_reset(1, "rst8");
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();

        // SHA-256("abc"), 32-bit beats, sink always ready
        capture(0, ABC);
        drain(0, 0, 99, -1, -1, -1, c);
        chk("abc32_cycles", c, 8);

        // Same digest, byte beats, ready toggling
        capture(1, ABC);
        drain(1, 1, 99, -1, -1, -1, c);
        chk("abc8_cycles", c, 63);

        // Overrun mid-stream, then clear in the bubble
        capture(0, rnd_digest());
        drain(0, 0, 99, 2, -1, -1, c);
        clr[0] = 1'b1;
        exp_ov[0] = 1'b0;
        tick();
        clr[0] = 1'b0;
        chk("ovr_cleared", ovr[0], 1'b0);

        // Overrun offered on the final-beat cycle
        capture(0, rnd_digest());
        drain(0, 0, 99, 7, -1, -1, c);
        chk("ovr_final_beat", ovr[0], 1'b1);
        clr[0] = 1'b1;
        exp_ov[0] = 1'b0;
        tick();
        clr[0] = 1'b0;

        // Simultaneous set and clear, then a plain clear mid-stream
        capture(0, rnd_digest());
        drain(0, 2, 99, 1, 1, 1, c);
        capture(0, rnd_digest());
        drain(0, 2, 99, -1, -1, 3, c);

        // Reset after beat 3 of 8, with overrun set
        capture(0, rnd_digest());
        drain(0, 0, 3, 1, -1, -1, c);
        chk("pre_reset_ovr", ovr[0], 1'b1);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        exp_ov[0] = 1'b0;
        exp_ov[1] = 1'b0;
        check_idle_reset(0, "midrst32");
        tick();
        chk("midrst_hold_valid", ovld[0], 1'b0);
        chk("midrst_hold_last", olast[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        capture(0, ABC);
        drain(0, 0, 99, -1, -1, -1, c);
        chk("post_reset_cycles", c, 8);

        // Back-to-back digests: 8 beats, one bubble, 8 beats
        capture(0, rnd_digest());
        drain(0, 0, 99, -1, -1, -1, c1);
        capture(0, rnd_digest());
        drain(0, 0, 99, -1, -1, -1, c2);
        chk("b2b_first_cycles", c1, 8);
        chk("b2b_second_cycles", c2, 8);

        // Random digests with random backpressure on both widths
        for (int n = 0; n < 3; n++) begin
            capture(0, rnd_digest());
            drain(0, 2, 99, -1, -1, -1, c);
            capture(1, rnd_digest());
            drain(1, 2, 99, -1, -1, -1, c);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
